// File: rtl/onehot_dispatch_decoder.sv
// -----------------------------------------------------------------------------
// onehot_dispatch_decoder
//
// Receive end of the encoded-request path. Encoded request indices arrive over
// a valid/ready handshake and are queued in arrival order. The queue head is
// re-expanded to a one-hot select, which is held until the consumer
// acknowledges it. A per-line pending bitmap records which indices are queued.
// Duplicate indices and out-of-range indices are dropped, and each drop raises
// a one-cycle error pulse.
//
// Ports
//   clk, rst    : rising-edge clock; asynchronous active-high reset
//   in_idx      : encoded request index
//   in_valid    : in_idx is valid
//   in_ready    : queue can accept (!full && !rst), combinational
//   out_onehot  : 1 << head index while out_valid, else zero (registered)
//   out_valid   : head entry presented (registered)
//   out_ack     : consumer done with head; pops while out_valid
//   pending     : bit i set while index i is queued
//   count       : number of queued entries (0..DEPTH)
//   dup_drop    : one-cycle pulse when an accepted index was a duplicate
//   range_err   : one-cycle pulse when an accepted index was >= N_OUT
// -----------------------------------------------------------------------------
module onehot_dispatch_decoder #(
  parameter int N_OUT = 8,
  parameter int IDX_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT-1:0]       out_onehot,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [N_OUT-1:0]       pending,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dup_drop,
  output logic                   range_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W:0]   N_OUT_L = (IDX_W + 1)'(N_OUT);
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Expand an index to its one-hot line. Indices at or above N_OUT shift the
  // bit out of range and give all zeros.
  function automatic logic [N_OUT-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = {{(N_OUT-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [N_OUT-1:0]   pending_q, pending_d;
  logic [N_OUT-1:0]   onehot_q, onehot_d;
  logic               dup_q, dup_d;
  logic               rng_q, rng_d;
  logic [IDX_W-1:0]   mem_q [DEPTH];

  logic               in_ready_s;
  logic               xfer_s;
  logic               pop_s;
  logic               push_s;
  logic               range_bad_s;
  logic               dup_s;
  logic [IDX_W-1:0]   head_idx_s;
  logic [IDX_W-1:0]   next_head_s;
  logic [N_OUT-1:0]   clear_mask_s;
  logic [N_OUT-1:0]   pend_after_pop_s;
  logic [CNT_W-1:0]   remain_s;

  // Handshake, drop classification and next-state computation.
  always_comb begin
    // A pop in the same cycle never frees space for a push when the queue is full.
    in_ready_s       = (count_q != DEPTH_L) && !rst;
    xfer_s           = in_valid && in_ready_s;
    pop_s            = (state_q == ST_PRESENT) && out_ack;
    head_idx_s       = mem_q[rd_ptr_q];
    clear_mask_s     = pop_s ? idx_to_onehot(head_idx_s) : {N_OUT{1'b0}};
    // The duplicate check uses the bitmap after this cycle's pop has cleared
    // its bit, so re-pushing the index being popped is legal.
    pend_after_pop_s = pending_q & ~clear_mask_s;
    range_bad_s      = ({1'b0, in_idx} >= N_OUT_L);
    dup_s            = !range_bad_s && (|(pend_after_pop_s & idx_to_onehot(in_idx)));
    push_s           = xfer_s && !range_bad_s && !dup_s;

    wr_ptr_d  = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_s);
    count_d   = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    pending_d = pend_after_pop_s | (push_s ? idx_to_onehot(in_idx) : {N_OUT{1'b0}});
    dup_d     = xfer_s && dup_s;
    rng_d     = xfer_s && range_bad_s;

    // If memory holds nothing beyond the popped head, the next head can only
    // be the index that is being pushed in this cycle.
    remain_s = count_q - CNT_W'(pop_s);
    if (remain_s != {CNT_W{1'b0}}) begin
      next_head_s = mem_q[rd_ptr_d];
    end else begin
      next_head_s = in_idx;
    end

    case (state_q)
      ST_IDLE: begin
        if (push_s) begin
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (count_d == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_PRESENT) begin
      onehot_d = idx_to_onehot(next_head_s);
    end else begin
      onehot_d = {N_OUT{1'b0}};
    end
  end

  // Output FSM, pointers, occupancy, pending bitmap and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      pending_q <= {N_OUT{1'b0}};
      onehot_q  <= {N_OUT{1'b0}};
      dup_q     <= 1'b0;
      rng_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      dup_q     <= dup_d;
      rng_q     <= rng_d;
    end
  end

  // Queue storage. It needs no reset because it is read only at occupied slots.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_idx;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = (state_q == ST_PRESENT);
  assign out_onehot = onehot_q;
  assign pending    = pending_q;
  assign count      = count_q;
  assign dup_drop   = dup_q;
  assign range_err  = rng_q;

endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
module tb_onehot_dispatch_decoder;

  localparam int N_OUT = 8;
  localparam int IDX_W = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;

  // Main instance: 8 lines
  logic [IDX_W-1:0] in_idx;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_onehot;
  logic             out_valid;
  logic             out_ack;
  logic [7:0]       pending;
  logic [2:0]       count;
  logic             dup_drop;
  logic             range_err;

  // Second instance: 6 lines, so indices 6 and 7 are out of range
  logic [2:0]       in_idx6;
  logic             in_valid6;
  logic             in_ready6;
  logic [5:0]       out_onehot6;
  logic             out_valid6;
  logic             out_ack6;
  logic [5:0]       pending6;
  logic [2:0]       count6;
  logic             dup_drop6;
  logic             range_err6;

  onehot_dispatch_decoder #(.N_OUT(8), .IDX_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid), .in_ready(in_ready),
    .out_onehot(out_onehot), .out_valid(out_valid), .out_ack(out_ack),
    .pending(pending), .count(count), .dup_drop(dup_drop), .range_err(range_err)
  );

  onehot_dispatch_decoder #(.N_OUT(6), .IDX_W(3), .DEPTH(4)) dut6 (
    .clk(clk), .rst(rst), .in_idx(in_idx6), .in_valid(in_valid6), .in_ready(in_ready6),
    .out_onehot(out_onehot6), .out_valid(out_valid6), .out_ack(out_ack6),
    .pending(pending6), .count(count6), .dup_drop(dup_drop6), .range_err(range_err6)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered queue of indices plus the expected error pulses
  int   mq[$];
  logic exp_dup = 1'b0;
  logic exp_rng = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_pending();
    logic [63:0] p = 64'd0;
    foreach (mq[i]) p = p | (64'd1 << mq[i]);
    return p;
  endfunction

  function automatic logic [63:0] model_onehot();
    if (mq.size() > 0) return 64'd1 << mq[0];
    return 64'd0;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out_valid"},  {63'd0, out_valid},  {63'd0, mq.size() > 0});
    check_eq({tag, ".out_onehot"}, {56'd0, out_onehot}, model_onehot());
    check_eq({tag, ".pending"},    {56'd0, pending},    model_pending());
    check_eq({tag, ".count"},      {61'd0, count},      64'(mq.size()));
    check_eq({tag, ".in_ready"},   {63'd0, in_ready},   {63'd0, mq.size() != DEPTH});
    check_eq({tag, ".dup_drop"},   {63'd0, dup_drop},   {63'd0, exp_dup});
    check_eq({tag, ".range_err"},  {63'd0, range_err},  {63'd0, exp_rng});
  endtask

  // Check current outputs, apply one cycle of stimulus, update the model,
  // then advance to the next falling edge.
  task automatic cycle(input string tag, input logic v, input int idx, input logic ack);
    logic pop;
    logic xfer;
    logic found;
    check_outputs(tag);
    in_valid = v;
    in_idx   = 3'(idx);
    out_ack  = ack;
    pop  = (mq.size() > 0) && ack;
    xfer = v && (mq.size() != DEPTH);
    exp_dup = 1'b0;
    exp_rng = 1'b0;
    if (pop) void'(mq.pop_front());
    if (xfer) begin
      if (idx >= N_OUT) begin
        exp_rng = 1'b1;
      end else begin
        found = 1'b0;
        foreach (mq[i]) if (mq[i] == idx) found = 1'b1;
        if (found) exp_dup = 1'b1;
        else mq.push_back(idx);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_idx = 3'd0; in_valid = 1'b0; out_ack = 1'b0;
    in_idx6 = 3'd0; in_valid6 = 1'b0; out_ack6 = 1'b0;
    #1;
    check_eq("rst.in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst.count", {61'd0, count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel.in_ready", {63'd0, in_ready}, 64'd1);

    // Single push and pop of index 5
    cycle("t1.push5", 1'b1, 5, 1'b0);
    check_eq("t1.onehot", {56'd0, out_onehot}, 64'h20);
    cycle("t1.ack", 1'b0, 0, 1'b1);
    cycle("t1.idle", 1'b0, 0, 1'b0);

    // Fill to capacity, stall a fifth push, then drain with ack held
    cycle("t2.p3", 1'b1, 3, 1'b0);
    cycle("t2.p1", 1'b1, 1, 1'b0);
    cycle("t2.p7", 1'b1, 7, 1'b0);
    cycle("t2.p0", 1'b1, 0, 1'b0);
    check_eq("t2.full_ready", {63'd0, in_ready}, 64'd0);
    cycle("t2.stall", 1'b1, 6, 1'b0);
    cycle("t2.ack0", 1'b1, 6, 1'b1);
    check_eq("t2.head1", {56'd0, out_onehot}, 64'h02);
    cycle("t2.ack1", 1'b0, 6, 1'b1);
    cycle("t2.ack2", 1'b0, 6, 1'b1);
    cycle("t2.ack3", 1'b0, 6, 1'b1);
    cycle("t2.ack4", 1'b0, 0, 1'b1);
    cycle("t2.done", 1'b0, 0, 1'b0);

    // Duplicate push of index 2
    cycle("t3.p2", 1'b1, 2, 1'b0);
    cycle("t3.dup", 1'b1, 2, 1'b0);
    check_eq("t3.dup_pulse", {63'd0, dup_drop}, 64'd1);
    cycle("t3.after", 1'b0, 0, 1'b1);

    // Pop of index 4 and push of index 4 in the same cycle
    cycle("t4.p4", 1'b1, 4, 1'b0);
    cycle("t4.swap", 1'b1, 4, 1'b1);
    check_eq("t4.onehot", {56'd0, out_onehot}, 64'h10);
    cycle("t4.drain", 1'b0, 0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle("rnd", ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 40));
    end
    cycle("rnd.end", 1'b0, 0, 1'b0);

    // Six-line instance: range errors and top valid line
    in_valid = 1'b0; out_ack = 1'b0;
    in_valid6 = 1'b1; in_idx6 = 3'd7;
    @(posedge clk); @(negedge clk);
    check_eq("t5.rng7", {63'd0, range_err6}, 64'd1);
    check_eq("t5.cnt0", {61'd0, count6}, 64'd0);
    check_eq("t5.pend0", {58'd0, pending6}, 64'd0);
    check_eq("t5.valid0", {63'd0, out_valid6}, 64'd0);
    in_idx6 = 3'd5;
    @(posedge clk); @(negedge clk);
    in_valid6 = 1'b0;
    check_eq("t5.rng_clr", {63'd0, range_err6}, 64'd0);
    check_eq("t5.onehot5", {58'd0, out_onehot6}, 64'h20);
    check_eq("t5.pend5", {58'd0, pending6}, 64'h20);
    check_eq("t5.cnt1", {61'd0, count6}, 64'd1);
    in_valid6 = 1'b1; in_idx6 = 3'd6;
    @(posedge clk); @(negedge clk);
    in_valid6 = 1'b0;
    check_eq("t5.rng6", {63'd0, range_err6}, 64'd1);
    check_eq("t5.cnt_keep", {61'd0, count6}, 64'd1);
    out_ack6 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ack6 = 1'b0;
    check_eq("t5.empty", {63'd0, out_valid6}, 64'd0);
    check_eq("t5.cnt_empty", {61'd0, count6}, 64'd0);

    // Reset asserted mid-cycle with three entries queued
    cycle("t6.p1", 1'b1, 1, 1'b0);
    cycle("t6.p2", 1'b1, 2, 1'b0);
    cycle("t6.p3", 1'b1, 3, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("t6.rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t6.rst_onehot", {56'd0, out_onehot}, 64'd0);
    check_eq("t6.rst_pending", {56'd0, pending}, 64'd0);
    check_eq("t6.rst_count", {61'd0, count}, 64'd0);
    check_eq("t6.rst_ready", {63'd0, in_ready}, 64'd0);
    mq.delete();
    exp_dup = 1'b0;
    exp_rng = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6.rel_ready", {63'd0, in_ready}, 64'd1);
    cycle("t6.ack_idle", 1'b0, 0, 1'b1);
    cycle("t6.p6", 1'b1, 6, 1'b0);
    check_eq("t6.fresh_head", {56'd0, out_onehot}, 64'h40);
    cycle("t6.drain", 1'b0, 0, 1'b1);
    cycle("t6.final", 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
